execute_sequencer: RTL

Control sequencer for the execute stage. It accepts one decoded instruction at a time from the register-read stage and issues a one-cycle start pulse to the selected execution unit (alu, branch, jump, shift, store). It waits for that unit's done pulse, then loads and holds the result for the writeback/memory stage under valid/stall handshake. It also handles flush, illegal unit selection and a per-instruction watchdog timeout.

---
 rtl/execute_sequencer.sv | 111 +++++++++++
 1 files changed

// File: rtl/execute_sequencer.sv
// rtl/execute_sequencer.sv - execute-stage sequencer: issues one instruction to a unit,
// waits for its done pulse under a watchdog, and holds the result for the next stage.
module execute_sequencer #(
   parameter int NUM_UNITS      = 5,
   parameter int TIMEOUT_CYCLES = 64,
   parameter int EXC_ILLEGAL    = 2,
   parameter int EXC_TIMEOUT    = 24
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 flush,
   input  logic                 read_valid,
   output logic                 read_stall,
   input  logic [NUM_UNITS-1:0] unit_sel,
   output logic                 capture,
   output logic [NUM_UNITS-1:0] start,
   input  logic [NUM_UNITS-1:0] unit_done,
   output logic [NUM_UNITS-1:0] result_sel,
   output logic                 out_load,
   output logic                 valid,
   input  logic                 stall,
   output logic                 exception_valid_out,
   output logic [5:0]           exception_num_out,
   output logic                 busy
);
   localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [NUM_UNITS-1:0] SEL_ONE    = NUM_UNITS'(1);
   localparam logic [TW-1:0]        TIMER_ONE  = TW'(1);
   localparam logic [TW-1:0]        TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

   state_t                 state;
   logic [NUM_UNITS-1:0]   cur_sel;
   logic [TW-1:0]          timer;
   logic                   accept;
   logic                   sel_ok;
   logic                   hit;
   logic                   expire;

   assign accept = read_valid && !flush && (state == IDLE || (state == HOLD && !stall));
   // x & (x-1) clears the lowest set bit, so a zero result means at most one bit was set
   assign sel_ok = (unit_sel != '0) && ((unit_sel & (unit_sel - SEL_ONE)) == '0);
   assign hit    = (state == ISSUE || state == WAIT) && ((unit_done & cur_sel) != '0);
   assign expire = (state == WAIT) && (timer == TIMER_LAST);

   assign capture    = accept;
   assign start      = (state == ISSUE && !flush) ? cur_sel : '0;
   assign out_load   = !flush && (hit || expire);
   assign read_stall = (state == ISSUE) || (state == WAIT) || (state == HOLD && stall);
   assign valid      = (state == HOLD);
   assign busy       = (state != IDLE);
   assign result_sel = cur_sel;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state               <= IDLE;
         cur_sel             <= '0;
         timer               <= '0;
         exception_valid_out <= 1'b0;
         exception_num_out   <= '0;
      end else if (flush) begin
         state               <= IDLE;
         timer               <= '0;
         exception_valid_out <= 1'b0;
         exception_num_out   <= '0;
      end else if (accept) begin
         cur_sel <= unit_sel;
         if (sel_ok) begin
            state               <= ISSUE;
            exception_valid_out <= 1'b0;
            exception_num_out   <= '0;
         end else begin
            state               <= HOLD;
            exception_valid_out <= 1'b1;
            exception_num_out   <= 6'(EXC_ILLEGAL);
         end
      end else begin
         case (state)
            ISSUE: begin
               timer <= '0;
               state <= hit ? HOLD : WAIT;
            end
            WAIT: begin
               // done takes precedence over a coincident watchdog expiry
               if (hit) begin
                  state <= HOLD;
               end else if (expire) begin
                  state               <= HOLD;
                  exception_valid_out <= 1'b1;
                  exception_num_out   <= 6'(EXC_TIMEOUT);
               end else if (timer != '1) begin
                  timer <= timer + TIMER_ONE;
               end
            end
            HOLD: begin
               if (!stall) begin
                  state               <= IDLE;
                  exception_valid_out <= 1'b0;
                  exception_num_out   <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   a_sel_onehot: assert property (@(posedge clk) disable iff (reset)
      (state == ISSUE || state == WAIT) |-> $onehot(cur_sel));

endmodule
